// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// A grant is held for at most BURST_LEN transfers. FIFO full stalls the owner
// without releasing the grant.
// Ports:
//   clk, rst_n : write-domain clock, asynchronous active-low reset
//   req_i      : per-producer request
//   data_i     : flattened producer data, slice i = data_i[i*W_DATA +: W_DATA]
//   full_i     : FIFO full flag
//   gnt_o      : one-hot ready to the owner (combinational, low while full)
//   push_o     : FIFO push strobe (combinational)
//   wdata_o    : FIFO write data, zero when not pushing (combinational)
//   owner_o    : current owner index (registered, valid when busy_o)
//   busy_o     : grant held (registered)
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned W_DATA    = 8,
  parameter int unsigned BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*W_DATA-1:0]   data_i,
  input  logic                      full_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic                      push_o,
  output logic [W_DATA-1:0]         wdata_o,
  output logic [$clog2(N_REQ)-1:0]  owner_o,
  output logic                      busy_o
);

  localparam int unsigned OWN_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               arb_vld;
  logic [OWN_W-1:0]   arb_idx;
  logic [OWN_W-1:0]   cand;
  logic               own_req;
  logic               xfer;
  logic               last_beat;

  // Round-robin pick: scan last+1 .. last (last itself is the final candidate).
  always_comb begin
    arb_vld = 1'b0;
    arb_idx = last_q;
    cand    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = OWN_W'((32'(last_q) + k) % N_REQ);
      if (!arb_vld && req_i[cand]) begin
        arb_vld = 1'b1;
        arb_idx = cand;
      end
    end
  end

  assign own_req   = req_i[owner_q];
  assign xfer      = (state_q == GRANT) && own_req && !full_i;
  assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

  // State and arbitration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OWN_W'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: grant from idle, count beats, release and hand over with no bubble.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          state_d = GRANT;
          owner_d = arb_idx;
          last_d  = arb_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // Withdrawn owner has req low, so it is naturally excluded from the pick.
        if (!own_req || (xfer && last_beat)) begin
          cnt_d = '0;
          if (arb_vld) begin
            owner_d = arb_idx;
            last_d  = arb_idx;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write-port outputs follow full_i/req_i in the same cycle.
  always_comb begin
    gnt_o   = '0;
    push_o  = 1'b0;
    wdata_o = '0;
    if (state_q == GRANT) begin
      gnt_o[owner_q] = !full_i;
      push_o         = xfer;
      if (xfer) begin
        wdata_o = data_i[32'(owner_q) * W_DATA +: W_DATA];
      end
    end
  end

  assign busy_o  = (state_q == GRANT);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_r = '0;
  logic        full_r = 1'b0;
  logic [23:0] data_w;
  logic [2:0]  gnt_o;
  logic        push_o;
  logic [7:0]  wdata_o;
  logic [1:0]  owner_o;
  logic        busy_o;

  logic [7:0]  pdata [3];
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    logic [2:0] req;
    logic       full;
    logic [2:0] gnt;
    logic       push;
    logic [7:0] wdata;
    int         owner;
    logic       busy;
  } vec_t;

  always #5 clk = ~clk;

  always_comb data_w = {pdata[2], pdata[1], pdata[0]};

  fifo_wr_arbiter #(.N_REQ(3), .W_DATA(8), .BURST_LEN(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (req_r),
    .data_i  (data_w),
    .full_i  (full_r),
    .gnt_o   (gnt_o),
    .push_o  (push_o),
    .wdata_o (wdata_o),
    .owner_o (owner_o),
    .busy_o  (busy_o)
  );

  task automatic check(input string nm, input logic [2:0] eg, input logic ep,
                       input logic [7:0] ew, input int eo, input logic eb);
    n_vec++;
    if (gnt_o !== eg || push_o !== ep || wdata_o !== ew || busy_o !== eb ||
        (eo >= 0 && owner_o !== 2'(eo)) || (push_o === 1'b1 && full_r === 1'b1)) begin
      n_err++;
      $display("FAIL %s @%0t: got gnt=%b push=%b wdata=%h owner=%0d busy=%b; want gnt=%b push=%b wdata=%h owner=%0d busy=%b",
               nm, $time, gnt_o, push_o, wdata_o, owner_o, busy_o, eg, ep, ew, eo, eb);
    end
  endtask

  // Producers advance to their next word only after a transfer.
  task automatic advance(input logic [2:0] xs);
    for (int i = 0; i < 3; i++)
      if (xs[i]) pdata[i][5:0] = pdata[i][5:0] + 6'd1;
  endtask

  task automatic step(input string nm, input logic [2:0] eg, input logic ep,
                      input logic [7:0] ew, input int eo, input logic eb);
    logic [2:0] xs;
    @(negedge clk);
    check(nm, eg, ep, ew, eo, eb);
    xs = req_r & gnt_o;
    @(posedge clk);
    #1;
    advance(xs);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n  = 1'b0;
    req_r  = '0;
    full_r = 1'b0;
    @(negedge clk);
    check("reset", 3'b000, 1'b0, 8'h00, 0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic int rr(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (r[2'((last + k) % 3)]) return (last + k) % 3;
    return -1;
  endfunction

  initial begin
    vec_t       t1 [9];
    int         base [3];
    int         n [3];
    int         o;
    logic [5:0] exp_seq [3];
    int         m_owner, m_last, m_cnt;
    logic       m_busy, m_push, rel;
    logic [2:0] m_gnt, xs;
    logic [7:0] m_wdata;
    int         w;

    t1[0] = '{3'b001, 1'b0, 3'b000, 1'b0, 8'h00, -1, 1'b0};
    t1[1] = '{3'b001, 1'b0, 3'b001, 1'b1, 8'hA0,  0, 1'b1};
    t1[2] = '{3'b001, 1'b0, 3'b001, 1'b1, 8'hA1,  0, 1'b1};
    t1[3] = '{3'b001, 1'b0, 3'b001, 1'b1, 8'hA2,  0, 1'b1};
    t1[4] = '{3'b001, 1'b0, 3'b001, 1'b1, 8'hA3,  0, 1'b1};
    t1[5] = '{3'b001, 1'b0, 3'b001, 1'b1, 8'hA4,  0, 1'b1};
    t1[6] = '{3'b001, 1'b0, 3'b001, 1'b1, 8'hA5,  0, 1'b1};
    t1[7] = '{3'b000, 1'b0, 3'b001, 1'b0, 8'h00,  0, 1'b1};
    t1[8] = '{3'b000, 1'b0, 3'b000, 1'b0, 8'h00, -1, 1'b0};

    pdata[0] = 8'hA0; pdata[1] = 8'h00; pdata[2] = 8'h00;
    do_reset();

    // Single producer: burst of 4, zero-bubble re-grant, then withdraw.
    for (int i = 0; i < 9; i++) begin
      req_r  = t1[i].req;
      full_r = t1[i].full;
      step("single", t1[i].gnt, t1[i].push, t1[i].wdata, t1[i].owner, t1[i].busy);
    end

    // All three requesting: rotation 0,1,2,0 with 4 pushes each.
    do_reset();
    base[0] = 'h10; base[1] = 'h20; base[2] = 'h30;
    for (int i = 0; i < 3; i++) begin
      pdata[i] = 8'(base[i]);
      n[i] = 0;
    end
    req_r = 3'b111;
    step("rot_idle", 3'b000, 1'b0, 8'h00, -1, 1'b0);
    for (int g = 0; g < 4; g++)
      for (int k = 0; k < 4; k++) begin
        o = g % 3;
        step("rotate", 3'(1 << o), 1'b1, 8'(base[o] + n[o]), o, 1'b1);
        n[o]++;
      end

    // Owner 1 stalled by full mid-burst, then finishes and hands to 2.
    for (int k = 0; k < 2; k++) begin
      step("pre_full", 3'b010, 1'b1, 8'(base[1] + n[1]), 1, 1'b1);
      n[1]++;
    end
    full_r = 1'b1;
    for (int k = 0; k < 5; k++) step("full_hold", 3'b000, 1'b0, 8'h00, 1, 1'b1);
    full_r = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step("post_full", 3'b010, 1'b1, 8'(base[1] + n[1]), 1, 1'b1);
      n[1]++;
    end
    step("after_full", 3'b100, 1'b1, 8'(base[2] + n[2]), 2, 1'b1);

    // Owner 0 withdraws after one push; 2 takes over with a fresh burst count.
    do_reset();
    pdata[0] = 8'h40; pdata[1] = 8'h00; pdata[2] = 8'h80;
    req_r = 3'b101;
    step("wd_idle", 3'b000, 1'b0, 8'h00, -1, 1'b0);
    step("wd_push", 3'b001, 1'b1, 8'h40, 0, 1'b1);
    req_r = 3'b100;
    step("wd_drop", 3'b001, 1'b0, 8'h00, 0, 1'b1);
    req_r = 3'b101;
    for (int k = 0; k < 4; k++) step("wd_new", 3'b100, 1'b1, 8'(8'h80 + k), 2, 1'b1);
    step("wd_back", 3'b001, 1'b1, 8'h41, 0, 1'b1);

    // Asynchronous reset during the third push of a burst.
    do_reset();
    pdata[0] = 8'h50; pdata[1] = 8'h60; pdata[2] = 8'h70;
    req_r = 3'b001;
    step("ar_idle", 3'b000, 1'b0, 8'h00, -1, 1'b0);
    step("ar_push0", 3'b001, 1'b1, 8'h50, 0, 1'b1);
    step("ar_push1", 3'b001, 1'b1, 8'h51, 0, 1'b1);
    @(negedge clk);
    check("ar_push2", 3'b001, 1'b1, 8'h52, 0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("ar_async", 3'b000, 1'b0, 8'h00, 0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_r = 3'b110;
    step("ar_rel_idle", 3'b000, 1'b0, 8'h00, -1, 1'b0);
    step("ar_first", 3'b010, 1'b1, 8'h60, 1, 1'b1);

    // Random traffic against a round-robin reference and per-producer scoreboard.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pdata[i] = {2'(i), 6'd0};
      exp_seq[i] = '0;
    end
    m_busy = 1'b0; m_owner = 0; m_last = 2; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      m_push  = m_busy && req_r[2'(m_owner)] && !full_r;
      m_gnt   = (m_busy && !full_r) ? 3'(1 << m_owner) : 3'b000;
      m_wdata = m_push ? {2'(m_owner), exp_seq[m_owner]} : 8'h00;
      @(negedge clk);
      check("random", m_gnt, m_push, m_wdata, m_busy ? m_owner : -1, m_busy);
      xs = req_r & gnt_o;
      if (m_push) exp_seq[m_owner] = exp_seq[m_owner] + 6'd1;
      if (!m_busy) begin
        w = rr(req_r, m_last);
        if (w >= 0) begin
          m_busy = 1'b1; m_owner = w; m_last = w; m_cnt = 0;
        end
      end else begin
        rel = !req_r[2'(m_owner)] || (m_push && m_cnt == 3);
        if (m_push) m_cnt++;
        if (rel) begin
          w = rr(req_r, m_last);
          m_cnt = 0;
          if (w >= 0) begin
            m_owner = w; m_last = w;
          end else begin
            m_busy = 1'b0;
          end
        end
      end
      @(posedge clk);
      #1;
      advance(xs);
      for (int i = 0; i < 3; i++) begin
        if (xs[i])          req_r[i] = 1'($urandom % 2);
        else if (req_r[i])  req_r[i] = ($urandom % 8) != 0;
        else                req_r[i] = ($urandom % 3) == 0;
      end
      full_r = ($urandom % 4) == 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
